// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch with credit-limited pipelined memory requests,
// an in-order PC-tagged instruction queue, and redirect flush with in-flight discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);
  localparam int CW = 3;
  localparam logic [CW-1:0] DEP = CW'(DEPTH);
  typedef enum logic {BOOT, RUN} state_t;
  state_t        r_state, w_state_n;
  logic [31:0]   r_pc, r_resp_pc, w_redirect_pc;
  logic [CW-1:0] r_out_cnt, r_q_cnt, r_discard_cnt, w_used, w_wr_idx;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc [DEPTH];
  logic [31:0]   w_q_inst_n [DEPTH];
  logic [31:0]   w_q_pc_n [DEPTH];
  logic          w_fire, w_rsp, w_push, w_pop;
  assign w_redirect_pc = i_redirect_pc & ~32'd3;
  assign w_used        = r_out_cnt + r_q_cnt;
  assign w_fire        = o_imem_req && i_imem_gnt;
  assign w_rsp         = i_imem_rvalid && (r_out_cnt != '0);
  assign w_push        = w_rsp && (r_discard_cnt == '0) && !i_redirect;
  assign w_pop         = o_inst_valid && i_inst_ready;
  assign w_wr_idx      = r_q_cnt - CW'(w_pop);
  assign o_imem_addr   = r_pc;
  assign o_inst_valid  = (r_q_cnt != '0) && !i_redirect;
  assign o_inst        = r_q_inst[0];
  assign o_inst_pc     = r_q_pc[0];
  always_comb begin
    w_state_n  = r_state;
    o_imem_req = 1'b0;
    if (r_state == BOOT) w_state_n = RUN;
    else o_imem_req = !i_redirect && (w_used < DEP);
  end
  // Shift-register queue: slot 0 is the head and keeps its value once the queue drains.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_q_inst_n[i] = r_q_inst[i];
      w_q_pc_n[i]   = r_q_pc[i];
      if (w_pop && (i + 1 < DEPTH) && (CW'(i + 1) < r_q_cnt)) begin
        w_q_inst_n[i] = r_q_inst[(i + 1) % DEPTH];
        w_q_pc_n[i]   = r_q_pc[(i + 1) % DEPTH];
      end
      if (w_push && (CW'(i) == w_wr_idx)) begin
        w_q_inst_n[i] = i_imem_rdata;
        w_q_pc_n[i]   = r_resp_pc;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_out_cnt     <= '0;
      r_q_cnt       <= '0;
      r_discard_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      r_state       <= w_state_n;
      r_out_cnt     <= r_out_cnt + CW'(w_fire) - CW'(w_rsp);
      r_q_cnt       <= i_redirect ? '0 : r_q_cnt + CW'(w_push) - CW'(w_pop);
      r_pc          <= i_redirect ? w_redirect_pc : w_fire ? r_pc + 32'd4 : r_pc;
      r_resp_pc     <= i_redirect ? w_redirect_pc : w_push ? r_resp_pc + 32'd4 : r_resp_pc;
      r_discard_cnt <= i_redirect ? r_out_cnt - CW'(w_rsp)
                                  : r_discard_cnt - CW'(w_rsp && (r_discard_cnt != '0));
      for (int i = 0; i < DEPTH; i++) begin
        r_q_inst[i] <= w_q_inst_n[i];
        r_q_pc[i]   <= w_q_pc_n[i];
      end
    end
  end
  a_rvalid_credit: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_imem_rvalid && (r_out_cnt == '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench; responses are tagged with a redirect epoch and a
// queue model predicts the decoder-side stream, plus literal pins on key cycles.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RP    = 32'h8000_0000;
  logic        i_clk = 0, i_rst = 1;
  logic        o_imem_req, i_imem_gnt = 0, i_imem_rvalid = 0;
  logic [31:0] o_imem_addr, i_imem_rdata = 0, i_redirect_pc = 0, o_inst, o_inst_pc;
  logic        i_redirect = 0, o_inst_valid, i_inst_ready = 0;
  always #5 i_clk = ~i_clk;
  fetch_unit #(.RESET_PC(RP), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_inst_valid(o_inst_valid),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .i_inst_ready(i_inst_ready));
  typedef struct packed {logic [31:0] addr; int ep; int due;} req_t;
  typedef struct packed {logic [31:0] inst; logic [31:0] pc;} ent_t;
  req_t        pend[$];
  ent_t        mq[$];
  req_t        r;
  int          cyc = 0, n_checks = 0, n_err = 0, epoch = 0;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100, rdy_pct = 100, redir_pct = 0;
  logic [31:0] exp_pc = RP;
  bit          in_boot = 1, exp_req, exp_valid;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s at cycle %0d: condition never reached", nm, cyc);
  endtask
  always @(negedge i_clk) begin
    if (i_rst) begin
      mq.delete();
      pend.delete();
      exp_pc  = RP;
      epoch   = 0;
      in_boot = 1;
    end else begin
      exp_req   = !in_boot && !i_redirect && (pend.size() + mq.size() < DEPTH);
      exp_valid = (mq.size() != 0) && !i_redirect;
      chk("req", {31'd0, o_imem_req}, {31'd0, exp_req});
      if (exp_req) chk("addr", o_imem_addr, exp_pc);
      chk("valid", {31'd0, o_inst_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("inst", o_inst, mq[0].inst);
        chk("inst_pc", o_inst_pc, mq[0].pc);
      end
      r = '0;
      if (i_imem_rvalid && pend.size() != 0) r = pend.pop_front();
      if (i_redirect) begin
        mq.delete();
        epoch++;
        exp_pc = i_redirect_pc & ~32'd3;
      end else begin
        if (exp_valid && i_inst_ready) void'(mq.pop_front());
        if (i_imem_rvalid && r.ep == epoch) mq.push_back('{inst: mem(r.addr), pc: r.addr});
        if (o_imem_req && i_imem_gnt) exp_pc += 32'd4;
      end
      if (o_imem_req && i_imem_gnt)
        pend.push_back('{addr: o_imem_addr, ep: epoch, due: cyc + $urandom_range(lat_min, lat_max)});
      in_boot = 0;
    end
  end
  task automatic drive();
    i_imem_gnt    = $urandom_range(0, 99) < gnt_pct;
    i_inst_ready  = $urandom_range(0, 99) < rdy_pct;
    i_redirect    = !i_rst && ($urandom_range(0, 99) < redir_pct);
    i_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
    i_imem_rvalid = 0;
    i_imem_rdata  = $urandom();
    if (!i_rst && pend.size() != 0) begin
      if (pend[0].due <= cyc) begin
        i_imem_rvalid = 1;
        i_imem_rdata  = mem(pend[0].addr);
      end
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    cyc++;
    #1;
    drive();
  endtask
  task automatic wait_sig(input string nm, input bit want_valid);
    int k = 0;
    while (!(want_valid ? o_inst_valid : o_imem_req) && k < 40) begin
      step();
      #1;
      k++;
    end
    if (!(want_valid ? o_inst_valid : o_imem_req)) timeout(nm);
  endtask
  task automatic wait_two_out(input string nm, input bit due_next);
    int k = 0;
    while (!(pend.size() == 2 && (!due_next || pend[0].due == cyc + 1)) && k < 40) begin
      step();
      #1;
      k++;
    end
    if (k == 40) timeout(nm);
  endtask
  task automatic release_rst();
    @(posedge i_clk);
    cyc++;
    #1;
    i_rst = 0;
    drive();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) step();
    release_rst();
    #1 chk("boot_req", {31'd0, o_imem_req}, 32'd0);
    step(); #1;
    chk("first_req", {31'd0, o_imem_req}, 32'd1);
    chk("first_addr", o_imem_addr, RP);
    step(); #1;
    chk("second_addr", o_imem_addr, RP + 32'd4);
    chk("valid_c2", {31'd0, o_inst_valid}, 32'd0);
    step(); #1;
    chk("first_pc", o_inst_pc, RP);
    chk("first_inst", o_inst, 32'h9357_9BDF);
    chk("credit_c3", {31'd0, o_imem_req}, 32'd0);
    step(); #1;
    chk("second_pc", o_inst_pc, RP + 32'd4);
    chk("third_addr", o_imem_addr, RP + 32'd8);
    rdy_pct = 0;
    repeat (5) step();
    rdy_pct = 100;
    repeat (10) step();
    gnt_pct = 0;
    repeat (3) step();
    gnt_pct = 100;
    repeat (5) step();
    lat_min = 4; lat_max = 4;
    step(); i_redirect = 1; i_redirect_pc = 32'h10;
    #1;
    wait_two_out("two_outstanding", 0);
    step(); i_redirect = 1; i_redirect_pc = 32'h203;
    #1;
    chk("redir_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("redir_req", {31'd0, o_imem_req}, 32'd0);
    lat_min = 1; lat_max = 1;
    step(); #1;
    wait_sig("redir_req_wait", 0);
    chk("redir_addr", o_imem_addr, 32'h200);
    wait_sig("redir_valid_wait", 1);
    chk("redir_first_pc", o_inst_pc, 32'h200);
    chk("redir_first_inst", o_inst, 32'h1357_99DF);
    lat_min = 3; lat_max = 3;
    wait_two_out("rvalid_redirect_setup", 1);
    step(); i_redirect = 1; i_redirect_pc = 32'h400;
    #1;
    chk("rvalid_on_redirect", {31'd0, i_imem_rvalid}, 32'd1);
    lat_min = 1; lat_max = 1;
    step(); #1;
    wait_sig("rvr_valid_wait", 1);
    chk("rvr_first_pc", o_inst_pc, 32'h400);
    step(); i_redirect = 1; i_redirect_pc = 32'hFFFF_FFFE;
    step(); #1;
    wait_sig("wrap_req_wait", 0);
    chk("wrap_addr0", o_imem_addr, 32'hFFFF_FFFC);
    step(); #1;
    wait_sig("wrap_req_wait2", 0);
    chk("wrap_addr1", o_imem_addr, 32'h0000_0000);
    lat_max = 3; gnt_pct = 70; rdy_pct = 70; redir_pct = 8;
    repeat (3000) step();
    redir_pct = 0; gnt_pct = 100; rdy_pct = 0; lat_max = 1;
    repeat (8) step();
    #1 chk("full_valid", {31'd0, o_inst_valid}, 32'd1);
    @(posedge i_clk); cyc++; #1;
    i_rst = 1;
    drive();
    #1;
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_inst_pc", o_inst_pc, 32'd0);
    chk("rst_addr", o_imem_addr, RP);
    rdy_pct = 100;
    repeat (2) step();
    release_rst();
    #1 chk("reboot_req", {31'd0, o_imem_req}, 32'd0);
    step(); #1;
    chk("reboot_addr", o_imem_addr, RP);
    chk("reboot_req1", {31'd0, o_imem_req}, 32'd1);
    gnt_pct = 80; rdy_pct = 80; redir_pct = 5; lat_max = 2;
    repeat (500) step();
    redir_pct = 0;
    repeat (10) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
